// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory arbiter.
package mem_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_gnt_t;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core instruction/data ports plus unified memory port.
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_oe;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_we, mem_oe
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_we, mem_oe
  );
endinterface

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational grant select; round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_picker
  import mem_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
`ifdef MEM_ARB_RR_EN
  input  arb_gnt_t last_grant,
`endif
  output arb_gnt_t gnt
);
`ifdef MEM_ARB_RR_EN
  always_comb gnt = (i_req && d_req) ? ((last_grant == GNT_I) ? GNT_D : GNT_I)
                                     : (d_req ? GNT_D : GNT_I);
`else
  always_comb gnt = (d_req || !i_req) ? GNT_D : GNT_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction/data accesses onto one fixed-latency memory.
// Optional MEM_ARB_RR_EN selects round-robin grant instead of data-first priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);
  arb_state_t        state;
  arb_gnt_t          gnt, pick;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [WAIT_W-1:0] cnt;
  logic              any_req, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
`ifdef MEM_ARB_RR_EN
  arb_gnt_t          last_grant;
`endif
  mem_arb_picker picker (
    .i_req(bus.i_req),
    .d_req(bus.d_req),
`ifdef MEM_ARB_RR_EN
    .last_grant(last_grant),
`endif
    .gnt(pick)
  );
  always_comb begin
    any_req   = bus.i_req || bus.d_req;
    sel_we    = (pick == GNT_D) && bus.d_we;
    sel_addr  = (pick == GNT_D) ? bus.d_addr : bus.i_addr;
    sel_wdata = (pick == GNT_D) ? bus.d_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      gnt           <= GNT_I;
      addr          <= '0;
      wdata         <= '0;
      we            <= 1'b0;
      cnt           <= '0;
      bus.i_rdata   <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_ack     <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_oe    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant    <= GNT_I;
`endif
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        ARB_IDLE: if (any_req) begin
          state         <= ARB_ACCESS;
          gnt           <= pick;
          addr          <= sel_addr;
          wdata         <= sel_wdata;
          we            <= sel_we;
          cnt           <= WS;
          bus.mem_addr  <= sel_addr;
          bus.mem_wdata <= sel_wdata;
          bus.mem_oe    <= !sel_we;
          bus.mem_we    <= sel_we && (WS == '0);
`ifdef MEM_ARB_RR_EN
          last_grant    <= pick;
`endif
        end
        ARB_ACCESS: if (cnt == '0) begin
          state         <= ARB_DONE;
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
          bus.mem_oe    <= 1'b0;
          bus.mem_we    <= 1'b0;
          if (gnt == GNT_D) begin
            bus.d_ack   <= 1'b1;
            bus.d_rdata <= we ? '0 : bus.mem_rdata;
          end else begin
            bus.i_ack   <= 1'b1;
            bus.i_rdata <= bus.mem_rdata;
          end
        end else begin
          cnt           <= cnt - 1'b1;
          bus.mem_addr  <= addr;
          bus.mem_wdata <= wdata;
          bus.mem_oe    <= !we;
          // write strobe only on the cycle the counter will reach zero
          bus.mem_we    <= we && (cnt == WAIT_W'(1));
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule
